// File: rtl/calc_mem_ctrl.sv
// calc_mem_ctrl: sequences single-cycle store/recall/M+/M-/clear-all commands
// into oe/we/addr cycles on a shared tri-state bus to a small result memory
// with a registered read port, and hands results back with a done pulse.
module calc_mem_ctrl #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] slot,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          done,
    output logic          ovf,
    inout  wire  [DW-1:0] mem_data,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr
);

    localparam logic [2:0] OP_STORE  = 3'd0;
    localparam logic [2:0] OP_RECALL = 3'd1;
    localparam logic [2:0] OP_MADD   = 3'd2;
    localparam logic [2:0] OP_MSUB   = 3'd3;
    localparam logic [2:0] OP_CLEAR  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_WR,
        S_CLR,
        S_FIN
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [2:0]    op_reg;
    logic [AW-1:0] slot_reg;
    logic [DW-1:0] wdata_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic [DW-1:0] rdata_reg;
    logic          ovf_reg;

    logic          is_sub;
    logic [DW-1:0] operand_b;
    logic [DW-1:0] arith_result;
    logic          arith_ovf;
    logic [DW-1:0] bus_out;

    // Add/subtract of the bus value and the latched operand; subtraction is
    // a + ~b + 1, so the overflow rule is the same sign test on a and ~b.
    always_comb begin
        is_sub       = (op_reg == OP_MSUB);
        operand_b    = is_sub ? ~wdata_reg : wdata_reg;
        arith_result = mem_data + operand_b + DW'(is_sub);
        arith_ovf    = (mem_data[DW-1] == operand_b[DW-1]) &&
                       (arith_result[DW-1] != mem_data[DW-1]);
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    case (op)
                        OP_STORE:                     state_next = S_WR;
                        OP_RECALL, OP_MADD, OP_MSUB:  state_next = S_RD1;
                        OP_CLEAR:                     state_next = S_CLR;
                        default:                      state_next = S_FIN;
                    endcase
                end
            end
            S_RD1:   state_next = S_RD2;
            S_RD2:   state_next = (op_reg == OP_RECALL) ? S_FIN : S_WR;
            S_WR:    state_next = S_FIN;
            S_CLR:   state_next = (clr_cnt_reg == {AW{1'b1}}) ? S_FIN : S_CLR;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state so they are clean per cycle.
    always_comb begin
        req_ready   = (state_reg == S_IDLE);
        mem_oe      = (state_reg == S_RD1) || (state_reg == S_RD2);
        mem_we      = (state_reg == S_WR) || (state_reg == S_CLR);
        mem_addr    = (state_reg == S_CLR) ? clr_cnt_reg : slot_reg;
        done        = (state_reg == S_FIN);
        rdata_valid = (state_reg == S_FIN) &&
                      ((op_reg == OP_RECALL) || (op_reg == OP_MADD) ||
                       (op_reg == OP_MSUB));
        bus_out     = '0;
        if (state_reg == S_WR)
            bus_out = (op_reg == OP_STORE) ? wdata_reg : rdata_reg;
    end

    // Bus is driven only while writing; otherwise the memory may own it.
    assign mem_data = mem_we ? bus_out : {DW{1'bz}};

    assign rdata = rdata_reg;
    assign ovf   = ovf_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Command capture, clear sweep counter and result/overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg      <= '0;
            slot_reg    <= '0;
            wdata_reg   <= '0;
            clr_cnt_reg <= '0;
            rdata_reg   <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        op_reg      <= op;
                        slot_reg    <= slot;
                        wdata_reg   <= wdata;
                        clr_cnt_reg <= '0;
                        ovf_reg     <= 1'b0;
                    end
                end
                S_RD2: begin
                    // The memory is driving its registered read value here.
                    if (op_reg == OP_RECALL) begin
                        rdata_reg <= mem_data;
                    end else begin
                        rdata_reg <= arith_result;
                        ovf_reg   <= arith_ovf;
                    end
                end
                S_CLR: clr_cnt_reg <= clr_cnt_reg + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/calc_mem_ctrl.md
Name: calc_mem_ctrl

Overview:
Sequencing controller between the calculator datapath (keypad/ALU result path) and the 4-entry, 16-bit result memory. Turns single-cycle memory commands (store, recall, M+, M-, clear-all) into correctly timed oe/we/addr cycles on the shared tri-state data bus. Drives the bus only during its own write cycles. Returns recalled or updated values to the datapath with a one-cycle done pulse.

Parameters:
DW, 16, data width of the memory bus and operands
AW, 2, memory address width; clear-all sweeps 2**AW slots

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  command strobe; accepted only when req_ready=1
req_ready  output  1  high in IDLE only
op  input  3  0=STORE, 1=RECALL, 2=MADD, 3=MSUB, 4=CLEAR; 5-7 reserved
slot  input  AW  target memory slot
wdata  input  DW  store value, or M+/M- operand
rdata  output  DW  recalled value (RECALL) or new slot value (MADD/MSUB)
rdata_valid  output  1  one-cycle pulse, coincident with done, for RECALL/MADD/MSUB only
done  output  1  one-cycle pulse on command completion
ovf  output  1  signed overflow of the last MADD/MSUB; valid with done
mem_data  inout  DW  shared tri-state data bus to memory
mem_oe  output  1  memory output enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address

Behaviour:
- Reset (async): state=IDLE; req_ready=1; done=0, rdata_valid=0, ovf=0, rdata=0; mem_oe=0, mem_we=0, mem_addr=0; bus hi-Z. Reset mid-command aborts with no completion pulse. Because mem_we drops asynchronously, a pending write does not occur.
- Memory contract: synchronous write when we=1. Read is registered: an edge with oe=1, we=0 loads the memory output register, and the memory drives the bus while oe=1, we=0. The controller never asserts mem_oe and mem_we together. It drives mem_data only when mem_we=1; otherwise the bus is hi-Z.
- Accept: in IDLE with req_valid=1, register op, slot, and wdata on the edge, clear ovf, and leave IDLE. req_valid while busy is ignored (not queued).
- States: IDLE, RD1, RD2, WR, CLR, FIN.
- STORE: IDLE->WR (we=1, addr=slot, bus=wdata) -> FIN. Memory writes on the edge ending WR.
- RECALL: IDLE->RD1 (oe=1, addr=slot; memory register loads at end) -> RD2 (oe=1; controller samples mem_data into rdata at end) -> FIN.
- MADD/MSUB: RD1 -> RD2 (at end, result = bus + wdata or bus - wdata, mod 2**DW, registered; ovf = signed two's-complement overflow) -> WR (we=1, bus=result, same slot) -> FIN. rdata=result.
- CLEAR: CLR for 2**AW consecutive cycles: we=1, bus=0, addr=0,1,2,3 ascending. Then FIN.
- Reserved op: IDLE->FIN; no memory access, no rdata_valid.
- FIN: one cycle with done=1 (and rdata_valid=1 where applicable), oe=we=0, bus hi-Z, req_ready=0. Next cycle is IDLE.
- Latency from accept edge to done-high cycle, in cycles: STORE 2, RECALL 3, MADD/MSUB 4, CLEAR 5, reserved 1.
- Back-to-back: a new request is accepted in the IDLE cycle following FIN, so the minimum command spacing is latency+1 cycles.
- rdata holds its value until the next RECALL/MADD/MSUB completes. ovf holds until the next accept.
- Outputs mem_oe, mem_we, mem_addr, and the bus drive are decoded from the registered state, so they are glitch-free per cycle.

Test Plan:
- Reset then idle: after rst pulse -> req_ready=1, mem_oe=mem_we=0, mem_data=Z, done=0.
- STORE slot 2 = 16'h1234, then RECALL slot 2 -> done 2 cycles after the first accept. On the second command, mem_oe high for exactly 2 cycles, then rdata=16'h1234 with rdata_valid+done 3 cycles after its accept.
- STORE slot 1 = 16'h7FFF, then MADD slot 1 with 16'h0001 -> rdata=16'h8000, ovf=1. A following RECALL slot 1 returns 16'h8000. MSUB slot 1 with 16'h0001 -> rdata=16'h7FFF, ovf=1.
- STORE all slots non-zero, then CLEAR -> 4 consecutive cycles with we=1, addr 0..3, bus=0; done on cycle 5. RECALL of each slot returns 0.
- req_valid held high during a MADD with a different op -> ignored until FIN; the held request is accepted on the first IDLE cycle. mem_oe and mem_we are never both 1 throughout.
- Assert rst during the WR cycle of STORE slot 3 = 16'hBEEF (slot previously 16'h0005) -> no done pulse. RECALL slot 3 afterwards returns 16'h0005.
